// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit/receive framing blocks.
package fsk_pkg;

   localparam int   DATA_W         = 8;
   localparam int   CODE_W         = 9;
   localparam logic START_BIT      = 1'b0;
   localparam logic STOP_BIT       = 1'b1;
   // start + 9 coded bits + stop, added to the preamble length
   localparam int   FRAME_OVERHEAD = 11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      START    = 3'd2,
      DATA     = 3'd3,
      STOP     = 3'd4
   } fsk_state_e;

endpackage

// File: rtl/fsk_check_encode.sv
// Combinational check encoder: appends one parity bit above the data byte.
// Shared with the receive side, which re-encodes and compares.
module fsk_check_encode
   import fsk_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] coded
);

   // bit8 makes the 9-bit word's ones count even (or odd when PARITY_ODD=1)
   always_comb begin
      coded = {(^data) ^ PARITY_ODD, data};
   end

endmodule

// File: rtl/fsk_tx_frame_ctrl.sv
// Transmit frame sequencer: takes one byte per frame over valid/ready, then
// drives preamble, start bit, 9 coded bits (LSB first) and stop bit to the
// FSK modulator, each bit held for BIT_CYCLES clocks.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1; in_ready is only high in IDLE, so inputs are ignored mid-frame.
// All outputs are registered: they are loaded from the next-state decode so
// the first frame bit appears in the cycle right after the transfer edge.
module fsk_tx_frame_ctrl
   import fsk_pkg::*;
#(
   parameter int unsigned BIT_CYCLES    = 16,
   parameter int unsigned PREAMBLE_BITS = 8,
   parameter bit          PARITY_ODD    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] datain,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_en,
   output logic              busy,
   output logic              frame_done,
   output fsk_state_e        dbg_state
);

   localparam logic [15:0] CNT_LAST = 16'(BIT_CYCLES - 1);
   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BITS - 1);
   localparam logic [7:0]  DAT_LAST = 8'(CODE_W - 1);

   fsk_state_e        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        idx_q, idx_d;
   logic [CODE_W-1:0] word_q, word_d;
   logic [CODE_W-1:0] code;
   logic              bit_last;
   logic              tx_bit_d, tx_en_d, in_ready_d, frame_done_d;

   fsk_check_encode #(
      .PARITY_ODD (PARITY_ODD)
   ) u_encode (
      .data  (datain),
      .coded (code)
   );

   assign bit_last  = (cnt_q == CNT_LAST);
   assign dbg_state = state_q;

   // Next state, bit timer, bit index and registered-output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      word_d       = word_q;
      frame_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               word_d  = code;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = (PREAMBLE_BITS == 0) ? START : PREAMBLE;
            end
         end
         PREAMBLE: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_last) begin
               cnt_d = '0;
               if (idx_q == PRE_LAST) begin
                  idx_d   = '0;
                  state_d = START;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         START: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_last) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_last) begin
               cnt_d = '0;
               if (idx_q == DAT_LAST) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         STOP: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_last) begin
               cnt_d        = '0;
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Output values for the cycle after this edge, decoded from next state
      tx_bit_d   = STOP_BIT;
      tx_en_d    = 1'b1;
      in_ready_d = 1'b0;
      case (state_d)
         IDLE: begin
            tx_bit_d   = STOP_BIT;
            tx_en_d    = 1'b0;
            in_ready_d = 1'b1;
         end
         PREAMBLE: tx_bit_d = ~idx_d[0];
         START:    tx_bit_d = START_BIT;
         DATA:     tx_bit_d = word_d[idx_d[3:0]];
         STOP:     tx_bit_d = STOP_BIT;
         default: begin
            tx_bit_d   = STOP_BIT;
            tx_en_d    = 1'b0;
            in_ready_d = 1'b0;
         end
      endcase
   end

   // State, counters, latched word and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         word_q     <= '0;
         tx_bit     <= 1'b1;
         tx_en      <= 1'b0;
         busy       <= 1'b0;
         in_ready   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         tx_bit     <= tx_bit_d;
         tx_en      <= tx_en_d;
         busy       <= tx_en_d;
         in_ready   <= in_ready_d;
         frame_done <= frame_done_d;
      end
   end

endmodule
